// File: rtl/fc_cmd_dispatch.sv
// Host command FIFO feeding the flash controller one command at a time.
// Commands that cross a 256-byte half-page are split into two FC commands.
module fc_cmd_dispatch #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_valid,
  input  logic [32:0]   host_cmd,
  output logic          host_ready,
  output logic [32:0]   fc_cmd,
  input  logic          fc_done,
  output logic          busy,
  output logic [AW:0]   q_count,
  output logic [7:0]    drop_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_RDY,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [AW:0] FULL = DEPTH[AW:0];

  state_t         state, state_nx;
  logic [32:0]    mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [AW:0]    count_nx;
  logic [32:0]    cur, part_b;
  logic           split;

  logic           pop, push, drop, accept, len_zero;
  logic [32:0]    head, part_a, part_b_nx;
  logic [7:0]     off;
  logic [6:0]     len, len1;
  logic [8:0]     sum9;
  logic           need_split;

  assign pop      = (state == LOAD);
  assign accept   = host_ready | pop;
  assign len_zero = (host_cmd[6:0] == 7'd0);
  assign push     = host_valid & accept & ~len_zero;
  assign drop     = host_valid & accept & len_zero;
  assign busy     = (state != IDLE) | (q_count != '0);

  always_comb begin
    count_nx = q_count;
    if (push && !pop)
      count_nx = q_count + (AW+1)'(1);
    else if (pop && !push)
      count_nx = q_count - (AW+1)'(1);
  end

  // Half-page split of the head entry
  assign head       = mem[rptr];
  assign off        = head[21:14];
  assign len        = head[6:0];
  assign sum9       = {1'b0, off} + {2'b0, len};
  assign need_split = (sum9 > 9'd256);
  assign len1       = 7'(9'd256 - {1'b0, off});
  assign part_a     = need_split ? {head[32:7], len1} : head;
  assign part_b_nx  = {head[32],
                       head[31:14] + 18'(len1),
                       head[13:7] + len1,
                       len - len1};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (q_count != '0) state_nx = LOAD;
      LOAD:      state_nx = WAIT_RDY;
      WAIT_RDY:  if (fc_done) state_nx = ISSUE;
      ISSUE:     state_nx = WAIT_BUSY;
      WAIT_BUSY: if (!fc_done) state_nx = WAIT_DONE;
      WAIT_DONE: if (fc_done) state_nx = split ? WAIT_RDY : IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= host_cmd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      q_count    <= '0;
      host_ready <= 1'b1;
      drop_cnt   <= '0;
      cur        <= '0;
      part_b     <= '0;
      split      <= 1'b0;
      fc_cmd     <= '0;
    end else begin
      state      <= state_nx;
      q_count    <= count_nx;
      host_ready <= (count_nx < FULL);
      fc_cmd     <= (state_nx == ISSUE) ? cur : '0;
      if (push)
        wptr <= wptr + AW'(1);
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      if (pop) begin
        rptr   <= rptr + AW'(1);
        cur    <= part_a;
        part_b <= part_b_nx;
        split  <= need_split;
      end else if (state == WAIT_DONE && fc_done && split) begin
        cur   <= part_b;
        split <= 1'b0;
      end
    end
  end

endmodule
